// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// Purpose:
//   Serialises one byte at a time onto an 8N1 UART line (start bit, 8 data
//   bits LSB first, stop bit), followed by a single CLEANUP cycle. Each serial
//   bit lasts CLKS_PER_BIT clock cycles. All outputs come straight from
//   flip-flops, so there is no combinational path from any input to any output.
//
// Optional feature:
//   UART_TX_PARITY_EN - when defined, a PARITY state is inserted between DATA
//   and STOP. It drives the even-parity bit (XOR of the 8 latched bits). When
//   it is undefined, no parity state and no parity logic exist.
//
// Handshake (valid/ready):
//   o_tx_done acts as "ready". A byte is accepted on any rising edge where
//   the block is idle (o_tx_done=1) and tx_data_valid=1; tx_byte is captured
//   on that same edge. o_tx_done falls in the very next cycle and stays low
//   for the whole frame. While the block is busy, tx_data_valid and tx_byte
//   are ignored. If valid is still high on the first idle cycle after a
//   frame, the next byte is accepted immediately.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   tx_data_valid in   byte-offer strobe
//   tx_byte       in   [7:0] byte to send, qualified by tx_data_valid
//   o_tx_serial   out  UART line, idles high
//   o_tx_active   out  high while a frame is on the line
//   o_tx_done     out  high when idle and able to accept a byte
//   dbg_state     out  [2:0] current FSM state (registered), for observation
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_data_valid,
    input  logic [7:0] tx_byte,
    output logic       o_tx_serial,
    output logic       o_tx_active,
    output logic       o_tx_done,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY  = 3'd3,
`endif
        S_STOP    = 3'd4,
        S_CLEANUP = 3'd5
    } state_t;

    // Terminal count of the per-bit counter.
    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        serial_q, serial_d;
    logic        active_q, active_d;
    logic        done_q, done_d;
    logic        bit_end;

    assign bit_end = (cnt_q == LAST_CNT);

    // -----------------------------------------------------------------------
    // Registers. The outputs are registered copies of values decoded from
    // the *next* state, so they line up with the state they describe.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 16'd0;
            idx_q    <= 3'd0;
            shift_q  <= 8'd0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic: sequencing, bit timing and byte capture.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                idx_d = 3'd0;
                if (tx_data_valid) begin
                    shift_d = tx_byte;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (bit_end) begin
                    cnt_d   = 16'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    cnt_d = 16'd0;
                    if (idx_q == 3'd7) begin
                        idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = 16'd0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif

            S_STOP: begin
                if (bit_end) begin
                    cnt_d   = 16'd0;
                    state_d = S_CLEANUP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_CLEANUP: begin
                cnt_d   = 16'd0;
                idx_d   = 3'd0;
                state_d = S_IDLE;
            end

            default: begin
                cnt_d   = 16'd0;
                idx_d   = 3'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode from the next state. shift_d is used, not shift_q, so
    // that the byte being captured on this edge is already visible; outside
    // the capture edge the two are equal.
    // -----------------------------------------------------------------------
    always_comb begin
        serial_d = 1'b1;
        active_d = 1'b0;
        done_d   = 1'b0;

        case (state_d)
            S_IDLE: begin
                done_d = 1'b1;
            end
            S_START: begin
                serial_d = 1'b0;
                active_d = 1'b1;
            end
            S_DATA: begin
                serial_d = shift_d[idx_d];
                active_d = 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                serial_d = ^shift_d;
                active_d = 1'b1;
            end
`endif
            S_STOP: begin
                active_d = 1'b1;
            end
            S_CLEANUP: begin
                active_d = 1'b0;
            end
            default: begin
                done_d = 1'b1;
            end
        endcase
    end

    assign o_tx_serial = serial_q;
    assign o_tx_active = active_q;
    assign o_tx_done   = done_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, is the number of clk cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 clk  input  1  system clock; all logic SHALL be rising-edge triggered on clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 tx_data_valid  input  1  byte-offer strobe from the message controller.
REQ-005 tx_byte  input  8  byte to transmit, qualified by tx_data_valid.
REQ-006 o_tx_serial  output  1  UART line; idle level is high.
REQ-007 o_tx_active  output  1  high while a frame is on the line.
REQ-008 o_tx_done  output  1  ready/complete level: high when idle and able to accept a byte, low while busy.

Function
REQ-009 FSM states SHALL be IDLE, START, DATA, PARITY (present only when the Configuration macro is defined), STOP and CLEANUP; the encoding is free.
REQ-010 IDLE: o_tx_serial=1, o_tx_active=0, o_tx_done=1, and the baud counter and bit index are held at 0.
REQ-011 Acceptance: if tx_data_valid=1 in IDLE at edge N, tx_byte SHALL be latched into a shift register and the FSM SHALL enter START.
REQ-012 At edge N+1 the outputs SHALL be o_tx_serial=0, o_tx_active=1 and o_tx_done=0.
REQ-013 Each of START, each DATA bit, PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a 16-bit counter that counts 0..CLKS_PER_BIT-1 and then wraps to 0 on a state or bit advance.
REQ-014 DATA SHALL send bit 0 first and bit 7 last; a 3-bit index SHALL advance on each counter wrap, and the FSM SHALL leave DATA after index 7.
REQ-015 STOP SHALL drive o_tx_serial=1.
REQ-016 CLEANUP SHALL last 1 cycle with o_tx_serial=1, o_tx_active=0 and o_tx_done=0, and SHALL then go to IDLE, where o_tx_done returns to 1.
REQ-017 Total busy time SHALL be 10*CLKS_PER_BIT+1 cycles, or 11*CLKS_PER_BIT+1 with parity.
REQ-018 tx_data_valid and tx_byte SHALL be ignored outside IDLE; a latched byte SHALL be unaffected by input changes mid-frame.
REQ-019 If tx_data_valid is still high on the first IDLE cycle after CLEANUP, a new frame SHALL start immediately (back-to-back operation).
REQ-020 o_tx_done SHALL fall no later than 1 cycle after acceptance, so an upstream SEND->WAIT handshake observes the low level before the frame ends.
REQ-021 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-022 On reset=1 at any edge, including mid-frame, the block SHALL enter IDLE with o_tx_serial=1, o_tx_active=0, o_tx_done=1, counter=0, index=0 and shift register=0.
REQ-023 The frame in progress SHALL be abandoned, not completed.
REQ-024 Reset SHALL take priority over tx_data_valid on the same edge.

Configuration
REQ-025 With macro UART_TX_PARITY_EN defined, a PARITY state between DATA and STOP SHALL drive the even-parity bit (XOR of the 8 latched bits) for CLKS_PER_BIT cycles.
REQ-026 With UART_TX_PARITY_EN undefined, DATA SHALL go directly to STOP, and no parity logic SHALL be synthesised.

Verification
REQ-027 CLKS_PER_BIT=4, no parity, send 0x53 -> o_tx_serial bits (each 4 cycles) 0,1,1,0,0,1,0,1,0,1; o_tx_done low for exactly 41 cycles.
REQ-028 CLKS_PER_BIT=4, UART_TX_PARITY_EN defined, send 0x53 then 0x07 -> parity bit 0 for 0x53 and 1 for 0x07; each frame busy for 45 cycles.
REQ-029 tx_data_valid held high with 0x0D and 0x23 alternating each frame -> back-to-back frames with 1 high CLEANUP cycle plus 1 IDLE cycle between stop bit and next start bit; both bytes decoded correctly.
REQ-030 tx_byte changed from 0x41 to 0xFF during DATA bit 3 -> line still carries 0x41.
REQ-031 reset asserted 1 cycle during DATA bit 5 -> next cycle o_tx_serial=1, o_tx_done=1, o_tx_active=0; a following send of 0x4E completes correctly.
REQ-032 Handshake model (valid high until o_tx_done low, then waits for high) sending the 12-byte string "SI-SIN2-P-#" followed by 0x0D -> all 12 bytes received in order with no byte dropped or duplicated.
